// File: rtl/r0_mux_pkg.sv
// Shared constants for the R0 routing block.
// Operation codes and the default datapath width.
package r0_mux_pkg;

    localparam int R0_WIDTH = 8;

    localparam logic [1:0] ST_HOLD  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_SWAP  = 2'b10;
    localparam logic [1:0] ST_R0OUT = 2'b11;

endpackage

// File: rtl/r0_multiplexer_if.sv
// Operand/result bundle between the operand buses and the R0 router.
// The master drives operation and operands; the slave returns outputs.
interface r0_multiplexer_if #(
    parameter int WIDTH = r0_mux_pkg::R0_WIDTH
);

    logic             en;
    logic [1:0]       state;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic [WIDTH-1:0] Output1;
    logic [WIDTH-1:0] Output2;

    modport master (
        output en, state, value1, value2,
        input  Output1, Output2
    );

    modport slave (
        input  en, state, value1, value2,
        output Output1, Output2
    );

endinterface

// File: rtl/r0_dff.sv
// Register with synchronous active-low clear and load enable.
module r0_dff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/r0_multiplexer.sv
// R0 router: hold, load, swap or broadcast R0 onto two registered outputs.
module r0_multiplexer
    import r0_mux_pkg::*;
#(
    parameter int WIDTH = R0_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    r0_multiplexer_if.slave bus
);

    logic [WIDTH-1:0] r0_q, r0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic             r0_ld, out1_ld, out2_ld;

    // Unknown or HOLD codes fall to default and load nothing.
    always_comb begin
        r0_ld   = 1'b0;
        out1_ld = 1'b0;
        out2_ld = 1'b0;
        r0_d    = bus.value1;
        out1_d  = bus.value1;
        out2_d  = bus.value2;
        if (bus.en) begin
            case (bus.state)
                ST_LOAD: begin
                    r0_ld   = 1'b1;
                    out1_ld = 1'b1;
                    out2_ld = 1'b1;
                end
                ST_SWAP: begin
                    out1_ld = 1'b1;
                    out2_ld = 1'b1;
                    out1_d  = bus.value2;
                    out2_d  = bus.value1;
                end
                ST_R0OUT: begin
                    out1_ld = 1'b1;
                    out2_ld = 1'b1;
                    out1_d  = r0_q;
                    out2_d  = r0_q;
                end
                default: ;
            endcase
        end
    end

    r0_dff #(.WIDTH(WIDTH)) u_r0 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (r0_ld),
        .d    (r0_d),
        .q    (r0_q)
    );

    r0_dff #(.WIDTH(WIDTH)) u_out1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out1_ld),
        .d    (out1_d),
        .q    (out1_q)
    );

    r0_dff #(.WIDTH(WIDTH)) u_out2 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out2_ld),
        .d    (out2_d),
        .q    (out2_q)
    );

    assign bus.Output1 = out1_q;
    assign bus.Output2 = out2_q;

endmodule

// File: tb/tb_r0_multiplexer.sv
// Bench for r0_multiplexer: directed sequence then random ops vs a model.
module tb_r0_multiplexer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] m_r0, m_o1, m_o2;

    r0_multiplexer_if #(.WIDTH(8)) bus ();

    r0_multiplexer #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h exp %02h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst,
                        input logic en, input logic [1:0] st,
                        input logic [7:0] v1, input logic [7:0] v2);
        logic [7:0] old_r0;
        rst_n      = rst;
        bus.en     = en;
        bus.state  = st;
        bus.value1 = v1;
        bus.value2 = v2;
        @(posedge clk);
        #1;
        old_r0 = m_r0;
        if (!rst) begin
            m_r0 = 8'h00; m_o1 = 8'h00; m_o2 = 8'h00;
        end else if (en) begin
            if (st == 2'd1) begin
                m_r0 = v1; m_o1 = v1; m_o2 = v2;
            end else if (st == 2'd2) begin
                m_o1 = v2; m_o2 = v1;
            end else if (st == 2'd3) begin
                m_o1 = old_r0; m_o2 = old_r0;
            end
        end
        chk({tag, ".o1"}, bus.Output1, m_o1);
        chk({tag, ".o2"}, bus.Output2, m_o2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_r0 = 8'h00; m_o1 = 8'h00; m_o2 = 8'h00;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.state = 2'd0;
        bus.value1 = 8'h00;
        bus.value2 = 8'h00;
        @(negedge clk);

        step("pre_ld", 1, 1, 2'd1, 8'h5A, 8'hA5);
        step("rst0",   0, 1, 2'd1, 8'd3, 8'd2);
        step("rst1",   0, 1, 2'd1, 8'd3, 8'd2);
        step("r0_clr", 1, 1, 2'd3, 8'hFF, 8'hFF);
        step("load",   1, 1, 2'd1, 8'd3, 8'd2);
        for (int i = 0; i < 10; i++)
            step("en_lo", 1, 0, 2'($urandom_range(0, 3)), 8'hAA, 8'h55);
        step("swap",   1, 1, 2'd2, 8'h12, 8'h34);
        step("r0_kept",1, 1, 2'd3, 8'hEE, 8'hDD);
        step("ld_c7",  1, 1, 2'd1, 8'hC7, 8'h11);
        step("bcast",  1, 1, 2'd3, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++)
            step("hold", 1, 1, 2'd0, 8'($urandom), 8'($urandom));
        step("rst_mid",1, 1, 2'd2, 8'h66, 8'h99);
        step("rst_mid",0, 1, 2'd1, 8'h77, 8'h88);
        step("post_rst",1, 1, 2'd3, 8'h77, 8'h88);

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r0_multiplexer.md
Name: r0_multiplexer

Overview:
- Registered routing block for the R0 datapath of the 8-bit computer.
- Each enabled clock edge does one of four things, chosen by a 2-bit state code:
  - hold;
  - load R0 and pass both operands through;
  - swap the operands;
  - broadcast R0 on both outputs.
- Sits between the register file / operand buses and the ALU input latches.

Parameters:
- WIDTH, 8, data width of value1, value2, R0, Output1 and Output2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- en  input  1  update enable; 0 = all registers hold.
- state  input  2  operation select (encoding below).
- value1  input  WIDTH  operand A.
- value2  input  WIDTH  operand B.
- Output1  output  WIDTH  registered output 1.
- Output2  output  WIDTH  registered output 2.

Interface decision: one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Internal registers: r0 (WIDTH), out1_q (WIDTH), out2_q (WIDTH).
  - Output1 = out1_q; Output2 = out2_q.
  - Outputs are purely registered, with no combinational input-to-output path.
- Reset: on a rising edge with rst_n=0, r0, Output1 and Output2 all become 0.
  - Reset has priority over en and state.
  - Reset mid-operation discards the operation of that cycle.
- Rising edge with rst_n=1 and en=0: all registers hold, regardless of state or the values.
- Rising edge with rst_n=1 and en=1, decoded on state:
  - 2'b00 HOLD: no register changes.
  - 2'b01 LOAD: r0 <= value1; Output1 <= value1; Output2 <= value2.
  - 2'b10 SWAP: Output1 <= value2; Output2 <= value1; r0 unchanged.
  - 2'b11 R0OUT: Output1 <= r0; Output2 <= r0 (the pre-edge r0 value); r0 unchanged.
- Latency: exactly one clock from sampled inputs to outputs. No handshake; en is a plain qualifier.
- No arithmetic. Widths match exactly, with no truncation or extension.
- X/unknown on state while en=1: the implementation treats it as HOLD (default branch holds).
- Back-to-back operations:
  - LOAD followed immediately by R0OUT yields the value loaded on the previous edge.
  - Each edge is independent; there are no multi-cycle states.

Decomposition:
- Shared package r0_mux_pkg holds:
  - localparams ST_HOLD=2'b00, ST_LOAD=2'b01, ST_SWAP=2'b10, ST_R0OUT=2'b11;
  - the default width constant 8.
- One natural sub-module: r0_dff, a WIDTH-bit register with synchronous active-low reset and load enable.
  - Instantiated three times: r0, out1_q, out2_q.
  - Load enables and D inputs come from a combinational decoder in the top.

Test Plan:
- Reset: rst_n=0 for 2 edges with en=1, state=01, value1=8'd3, value2=8'd2 -> Output1=0, Output2=0, r0=0.
- Load/pass: rst_n=1, en=1, state=01, value1=8'd3, value2=8'd2 -> after 1 edge Output1=3, Output2=2; r0=3.
- Enable low: after the load, en=0 and value1=8'hAA, value2=8'h55 over 10 edges, any state -> Output1 stays 3, Output2 stays 2.
- Swap: en=1, state=10, value1=8'h12, value2=8'h34 -> Output1=8'h34, Output2=8'h12; r0 still 3.
- R0 broadcast: LOAD value1=8'hC7, then next edge state=11 with value1=8'h00 -> Output1=Output2=8'hC7.
- Hold plus reset mid-run:
  - state=00, en=1 with changing values -> outputs unchanged.
  - Then rst_n=0 for one edge during state=01 -> all zero, with no load of the presented values.
